qcv_bus_arbiter: RTL and testbench

- Merges the core's instruction-fetch and data (LSU) memory interfaces onto a single shared req/gnt/rvalid memory port.
- Sits directly downstream of qcv_rv32i_core: instr_* and data_* core outputs connect here; the mem_* side connects to the unified SRAM/bus device.
- Arbitrates requests, holds the selection stable until grant, and routes in-order responses back through an outstanding-transaction FIFO.

---
 rtl/qcv_bus_arbiter.sv | 89 ++++++++
 tb/tb_qcv_bus_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/qcv_bus_arbiter.sv
// qcv_bus_arbiter: merges fetch and data ports onto one req/gnt/rvalid memory port with in-order response routing
module qcv_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o
);
  localparam int AW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic hold_sel, rr_data, full, sel_data, accept, pop, head;
  logic [MAX_OUTSTANDING-1:0] src_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
  // Selection is frozen while waiting for grant; fullness uses the registered count so rvalid never reaches req
  always_comb begin
    full = count == CW'(MAX_OUTSTANDING);
    sel_data = state == HOLD ? hold_sel : data_req_i & (DATA_PRIO | ~instr_req_i | rr_data);
    mem_req_o = state == HOLD ? (hold_sel ? data_req_i : instr_req_i) : ~full & (instr_req_i | data_req_i);
    mem_addr_o = mem_req_o ? (sel_data ? data_addr_i : instr_addr_i) : '0;
    mem_we_o = mem_req_o & sel_data & data_we_i;
    mem_be_o = mem_req_o ? (sel_data ? data_be_i : 4'hF) : 4'h0;
    mem_wdata_o = mem_req_o & sel_data ? data_wdata_i : '0;
    accept = mem_req_o & mem_gnt_i;
    instr_gnt_o = accept & ~sel_data;
    data_gnt_o = accept & sel_data;
    pop = mem_rvalid_i & (count != '0);
    head = src_q[rd_ptr];
    instr_rvalid_o = pop & ~head;
    data_rvalid_o = pop & head;
    instr_rdata_o = instr_rvalid_o ? mem_rdata_i : '0;
    data_rdata_o = data_rvalid_o ? mem_rdata_i : '0;
    instr_err_o = instr_rvalid_o & mem_err_i;
    data_err_o = data_rvalid_o & mem_err_i;
    busy_o = (count != '0) | (state == HOLD) | instr_req_i | data_req_i;
  end
  // Arbitration state, round-robin pointer and the source-id FIFO that routes responses back
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      hold_sel <= 1'b0;
      rr_data <= 1'b0;
      src_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= mem_req_o & ~mem_gnt_i ? HOLD : IDLE;
      if (state == IDLE) hold_sel <= sel_data;
      if (accept) begin
        src_q[wr_ptr] <= sel_data;
        wr_ptr <= inc(wr_ptr);
        rr_data <= ~sel_data;
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(accept) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_qcv_bus_arbiter.sv
// tb_qcv_bus_arbiter: randomized scoreboard bench for qcv_bus_arbiter against a transaction-level model
module tb_qcv_bus_arbiter;
  localparam int MO = 2;
  localparam bit DP = 1'b1;
  logic clk = 0, rst = 1;
  logic ireq = 0, dreq = 0, dwe = 0, gnt = 0, rvalid = 0, err = 0;
  logic [31:0] iaddr = 0, daddr = 0, dwdata = 0, rdata = 0;
  logic [3:0] dbe = 0;
  logic igr, irv, ierr, dgr, drv, derr, mreq, mwe, busy;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic [3:0] mbe;
  typedef struct {bit port; logic [31:0] d; bit e;} rsp_t;
  rsp_t sb[$];
  bit mq[$];
  int hold = -1;
  bit rr = 0, ig_last = 0, dg_last = 0;
  int ir_rate, dr_rate, g_rate, rv_rate;
  int n_cmp = 0, n_err = 0;

  qcv_bus_arbiter #(.MAX_OUTSTANDING(MO), .DATA_PRIO(DP)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(ireq), .instr_gnt_o(igr), .instr_rvalid_o(irv), .instr_addr_i(iaddr),
    .instr_rdata_o(irdata), .instr_err_o(ierr),
    .data_req_i(dreq), .data_gnt_o(dgr), .data_rvalid_o(drv), .data_we_i(dwe), .data_be_i(dbe),
    .data_addr_i(daddr), .data_wdata_i(dwdata), .data_rdata_o(drdata), .data_err_o(derr),
    .mem_req_o(mreq), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_we_o(mwe), .mem_be_o(mbe),
    .mem_addr_o(maddr), .mem_wdata_o(mwdata), .mem_rdata_i(rdata), .mem_err_i(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Response monitor: every host rvalid must match the next scoreboard entry, and vice versa
  always @(negedge clk) begin
    rsp_t r;
    #2;
    if (!rst && (irv || drv || sb.size() > 0)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_rvalid: got instr=%0b data=%0b expected none", irv, drv);
      end else begin
        r = sb.pop_front();
        chk("rsp_data_rvalid", 32'(drv), 32'(r.port));
        chk("rsp_instr_rvalid", 32'(irv), 32'(!r.port));
        chk("rsp_rdata", r.port ? drdata : irdata, r.d);
        chk("rsp_err", 32'(r.port ? derr : ierr), 32'(r.e));
        chk("rsp_other_rdata", r.port ? irdata : drdata, 0);
      end
    end
  end

  // One cycle of reference model: predict combinational outputs, then advance at the clock edge
  task automatic eval();
    bit er, es;
    if (rvalid && mq.size() > 0) sb.push_back('{port: mq[0], d: rdata, e: err});
    if (hold >= 0) begin
      es = hold[0];
      er = es ? dreq : ireq;
    end else if (mq.size() >= MO) begin
      es = 0;
      er = 0;
    end else begin
      er = ireq | dreq;
      es = dreq && (DP || !ireq || rr);
    end
    #1;
    chk("mem_req", 32'(mreq), 32'(er));
    chk("instr_gnt", 32'(igr), 32'(er && gnt && !es));
    chk("data_gnt", 32'(dgr), 32'(er && gnt && es));
    chk("mem_addr", maddr, !er ? 0 : es ? daddr : iaddr);
    chk("mem_we", 32'(mwe), 32'(er && es && dwe));
    chk("mem_be", 32'(mbe), !er ? 0 : es ? 32'(dbe) : 32'hF);
    chk("mem_wdata", mwdata, er && es ? dwdata : 0);
    chk("busy", 32'(busy), 32'(mq.size() != 0 || hold >= 0 || ireq || dreq));
    @(posedge clk);
    if (rvalid && mq.size() > 0) void'(mq.pop_front());
    if (er && gnt) begin
      mq.push_back(es);
      rr = !es;
    end
    hold = (er && !gnt) ? int'(es) : -1;
    ig_last = er && gnt && !es;
    dg_last = er && gnt && es;
  endtask

  task automatic dir(input bit ir, input logic [31:0] ia, input bit dr, input bit dw, input logic [31:0] da,
                     input bit g, input bit rv, input logic [31:0] rd, input bit er);
    @(negedge clk);
    ireq = ir; iaddr = ia; dreq = dr; dwe = dw; daddr = da; dbe = 4'h3; dwdata = 32'hCAFE0000 | da;
    gnt = g; rvalid = rv; rdata = rd; err = er;
    eval();
  endtask

  task automatic rand_cycle();
    @(negedge clk);
    if (!ireq || ig_last) begin
      ireq = $urandom_range(99) < ir_rate;
      iaddr = $urandom & 32'hFFFFFFFC;
    end else if ($urandom_range(99) < 2) ireq = 0;
    if (!dreq || dg_last) begin
      dreq = $urandom_range(99) < dr_rate;
      daddr = $urandom;
      dwdata = $urandom;
      dwe = 1'($urandom);
      dbe = 4'($urandom);
    end else if ($urandom_range(99) < 2) dreq = 0;
    gnt = $urandom_range(99) < g_rate;
    rvalid = mq.size() > 0 ? $urandom_range(99) < rv_rate : $urandom_range(99) < 5;
    rdata = $urandom;
    err = $urandom_range(9) == 0;
    eval();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; ireq = 0; dreq = 0; gnt = 0; rvalid = 0; err = 0;
    #1;
    chk("rst_mem_req", 32'(mreq), 0);
    chk("rst_gnts", {igr, dgr}, 0);
    chk("rst_rvalids", {irv, drv}, 0);
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_addr", maddr, 0);
    rst = 0;
    mq.delete();
    sb.delete();
    hold = -1; rr = 0; ig_last = 0; dg_last = 0;
  endtask

  initial begin
    do_reset();
    dir(1, 32'h80, 0, 0, 0, 1, 0, 0, 0);
    dir(0, 0, 0, 0, 0, 0, 1, 32'h13, 0);
    dir(1, 32'h84, 1, 0, 32'h100, 1, 0, 0, 0);
    dir(1, 32'h84, 0, 0, 0, 1, 1, 32'hA, 0);
    dir(0, 0, 0, 0, 0, 0, 1, 32'hB, 0);
    dir(1, 32'h88, 0, 0, 0, 0, 0, 0, 0);
    dir(1, 32'h88, 1, 1, 32'h200, 0, 0, 0, 0);
    dir(1, 32'h88, 1, 1, 32'h200, 0, 0, 0, 0);
    dir(1, 32'h88, 1, 1, 32'h200, 1, 0, 0, 0);
    dir(0, 0, 1, 1, 32'h200, 1, 0, 0, 0);
    dir(1, 32'h8C, 0, 0, 0, 1, 0, 0, 0);
    dir(1, 32'h8C, 0, 0, 0, 1, 1, 32'h1, 0);
    dir(1, 32'h8C, 0, 0, 0, 1, 0, 0, 0);
    dir(0, 0, 0, 0, 0, 0, 1, 32'h2, 1);
    dir(0, 0, 0, 0, 0, 0, 1, 32'h3, 0);
    dir(0, 0, 0, 0, 0, 0, 1, 32'h4, 0);
    dir(1, 32'h90, 0, 0, 0, 1, 0, 0, 0);
    dir(0, 0, 1, 1, 32'h300, 1, 0, 0, 0);
    do_reset();
    dir(0, 0, 0, 0, 0, 0, 1, 32'hDEAD, 0);
    for (int p = 0; p < 4; p++) begin
      ir_rate = 40 + 15 * p;
      dr_rate = 70 - 15 * p;
      g_rate = 30 + 20 * p;
      rv_rate = p == 1 ? 15 : 60;
      for (int c = 0; c < 600; c++) rand_cycle();
      if (p == 1) do_reset();
    end
    for (int c = 0; c < 100 && (mq.size() > 0 || hold >= 0); c++) begin
      @(negedge clk);
      ireq = 0; dreq = 0; gnt = 0; rvalid = mq.size() > 0; rdata = $urandom; err = 0;
      eval();
    end
    chk("drain_outstanding", mq.size(), 0);
    @(negedge clk);
    rvalid = 0;
    #4;
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
